// File: rtl/register_file_sb.sv
// 32x32 register file with same-cycle writeback bypass and a per-register pending-writer scoreboard.
// Reads, bypass and StallD are combinational; registers, counters and SbErr update at the clock edge.
module register_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic            UseA1,
  input  logic            UseA2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            IssueD,
  input  logic            RegWriteD,
  input  logic [AW-1:0]   RdD,
  input  logic            CancelV,
  input  logic [AW-1:0]   CancelRd,
  output logic            StallD,
  output logic            SbErr
);

  localparam int CMAX = (1 << PEND_W) - 1;

  logic [XLEN-1:0]   regs    [NREG];
  logic [PEND_W-1:0] cnt     [NREG];
  logic [PEND_W-1:0] cnt_nxt [NREG];
  logic              err_nxt;
  logic              hit1, hit2;
  logic              pend1, pend2;
  int                sum;

  assign hit1 = RegWriteW && (RdW == A1);
  assign hit2 = RegWriteW && (RdW == A2);

  always_comb begin
    RD1 = '0;
    if (A1 != '0) RD1 = hit1 ? ResultW : regs[A1];
  end

  always_comb begin
    RD2 = '0;
    if (A2 != '0) RD2 = hit2 ? ResultW : regs[A2];
  end

  // A writeback landing this cycle retires one pending writer before the stall decision.
  assign pend1  = cnt[A1] > PEND_W'(hit1);
  assign pend2  = cnt[A2] > PEND_W'(hit2);
  assign StallD = (UseA1 && (A1 != '0) && pend1) || (UseA2 && (A2 != '0) && pend2);

  always_comb begin
    err_nxt = 1'b0;
    sum     = 0;
    for (int r = 0; r < NREG; r++) cnt_nxt[r] = '0;
    for (int r = 1; r < NREG; r++) begin
      sum = int'(cnt[r]);
      if (IssueD && RegWriteD && !StallD && (RdD == AW'(r))) sum = sum + 1;
      if (RegWriteW && (RdW == AW'(r)))                      sum = sum - 1;
      if (CancelV && (CancelRd == AW'(r)))                   sum = sum - 1;
      if (sum > CMAX) begin
        cnt_nxt[r] = PEND_W'(CMAX);
        err_nxt    = 1'b1;
      end else if (sum < 0) begin
        cnt_nxt[r] = '0;
        err_nxt    = 1'b1;
      end else begin
        cnt_nxt[r] = PEND_W'(sum);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      SbErr <= 1'b0;
    end else begin
      if (RegWriteW && (RdW != '0)) regs[RdW] <= ResultW;
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      if (err_nxt) SbErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed and randomized checks of register_file_sb against an array/integer reference model.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [4:0]  A1, A2;
  logic        UseA1, UseA2;
  logic [31:0] RD1, RD2;
  logic        IssueD, RegWriteD;
  logic [4:0]  RdD;
  logic        CancelV;
  logic [4:0]  CancelRd;
  logic        StallD, SbErr;

  int checks = 0;
  int fails  = 0;

  logic [31:0] mregs [32];
  int          mcnt  [32];
  logic        merr;
  logic        mstall;

  register_file_sb dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .A1(A1), .A2(A2), .UseA1(UseA1), .UseA2(UseA2), .RD1(RD1), .RD2(RD2),
    .IssueD(IssueD), .RegWriteD(RegWriteD), .RdD(RdD), .CancelV(CancelV),
    .CancelRd(CancelRd), .StallD(StallD), .SbErr(SbErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (RegWriteW && RdW == a) return ResultW;
    return mregs[a];
  endfunction

  function automatic logic exp_pending(input logic use_a, input logic [4:0] a);
    int eff;
    eff = mcnt[a] - ((RegWriteW && RdW == a && a != 0) ? 1 : 0);
    return use_a && (a != 0) && (eff > 0);
  endfunction

  task automatic idle();
    RegWriteW = 0; RdW = 0; ResultW = 0; A1 = 0; A2 = 0; UseA1 = 0; UseA2 = 0;
    IssueD = 0; RegWriteD = 0; RdD = 0; CancelV = 0; CancelRd = 0;
  endtask

  // Compare combinational outputs against the model for the current inputs.
  task automatic eval();
    #1;
    mstall = exp_pending(UseA1, A1) || exp_pending(UseA2, A2);
    chk("rd1", RD1, exp_rd(A1));
    chk("rd2", RD2, exp_rd(A2));
    chk("stall", StallD, mstall);
  endtask

  // Advance one clock and apply the same cycle to the model.
  task automatic tick();
    int v;
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin mregs[r] = 0; mcnt[r] = 0; end
      merr = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        v = mcnt[r];
        if (IssueD && RegWriteD && !mstall && RdD == r) v = v + 1;
        if (RegWriteW && RdW == r) v = v - 1;
        if (CancelV && CancelRd == r) v = v - 1;
        if (v > 3) begin v = 3; merr = 1; end
        if (v < 0) begin v = 0; merr = 1; end
        mcnt[r] = v;
      end
      if (RegWriteW && RdW != 0) mregs[RdW] = ResultW;
    end
    #1;
    chk("sberr", SbErr, merr);
  endtask

  initial begin
    int r;
    for (int i = 0; i < 32; i++) begin mregs[i] = 0; mcnt[i] = 0; end
    merr = 0; mstall = 0;
    idle(); rst = 1;
    @(negedge clk);
    eval(); tick(); rst = 0;

    A1 = 5; UseA1 = 1; eval();
    chk("rst_rd1", RD1, 0); chk("rst_stall", StallD, 0); chk("rst_sberr", SbErr, 0);

    idle(); RegWriteW = 1; RdW = 5; ResultW = 32'hDEADBEEF; eval(); tick();
    idle(); A1 = 5; RegWriteW = 1; RdW = 0; ResultW = 32'h1234; eval();
    chk("rd_x5", RD1, 32'hDEADBEEF); chk("rd_x0", RD2, 0); tick();

    idle(); RegWriteW = 1; RdW = 7; ResultW = 32'hA5A5A5A5; A1 = 7; eval();
    chk("bypass_x7", RD1, 32'hA5A5A5A5); chk("x7_old", dut.regs[7], 0); tick();
    chk("x7_new", dut.regs[7], 32'hA5A5A5A5);

    idle(); IssueD = 1; RegWriteD = 1; RdD = 3; eval(); chk("iss3_nostall", StallD, 0); tick();
    idle(); A1 = 3; UseA1 = 1; eval(); chk("x3_stall_a", StallD, 1); tick();
    eval(); chk("x3_stall_b", StallD, 1); tick();
    RegWriteW = 1; RdW = 3; ResultW = 32'h33333333; eval();
    chk("x3_wb_nostall", StallD, 0); chk("x3_wb_rd1", RD1, 32'h33333333); tick();
    chk("cnt3_zero", 32'(dut.cnt[3]), 0);

    idle(); IssueD = 1; RegWriteD = 1; RdD = 9; eval(); tick(); eval(); tick();
    chk("cnt9_two", 32'(dut.cnt[9]), 2);
    idle(); UseA1 = 1; A1 = 9; RegWriteW = 1; RdW = 9; ResultW = 32'h99; eval();
    chk("x9_first_wb_stall", StallD, 1); tick();
    eval(); chk("x9_second_wb_clear", StallD, 0); tick();
    idle(); CancelV = 1; CancelRd = 9; eval(); tick();
    chk("cancel_sberr", SbErr, 1); chk("cnt9_floor", 32'(dut.cnt[9]), 0);

    idle(); RegWriteW = 1; RdW = 4; ResultW = 32'h44444444; eval(); tick();
    idle(); IssueD = 1; RegWriteD = 1; RdD = 4;
    repeat (4) begin eval(); tick(); end
    chk("cnt4_sat", 32'(dut.cnt[4]), 3); chk("sat_sberr", SbErr, 1);
    idle(); rst = 1; IssueD = 1; RegWriteD = 1; RdD = 4; eval(); tick(); rst = 0;
    idle(); A1 = 4; UseA1 = 1; eval();
    chk("rst_x4", RD1, 0); chk("rst2_stall", StallD, 0); chk("rst2_sberr", SbErr, 0);
    for (int i = 0; i < 32; i++) chk("rst_cnt", 32'(dut.cnt[i]), 0);

    idle(); IssueD = 1; RegWriteD = 1; RdD = 6; A1 = 6; UseA1 = 1; eval();
    chk("selfdep_nostall", StallD, 0); tick();
    eval(); chk("selfdep_stall", StallD, 1); tick();
    idle(); RegWriteW = 1; RdW = 6; ResultW = 32'h66; eval(); tick();

    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      RegWriteW = $urandom_range(0, 1);
      RdW       = 5'($urandom_range(0, 7));
      ResultW   = $urandom;
      A1        = 5'($urandom_range(0, 7));
      A2        = 5'($urandom_range(0, 7));
      UseA1     = $urandom_range(0, 1);
      UseA2     = $urandom_range(0, 1);
      IssueD    = $urandom_range(0, 1);
      RegWriteD = $urandom_range(0, 1);
      RdD       = 5'($urandom_range(0, 7));
      CancelV   = ($urandom_range(0, 5) == 0);
      CancelRd  = 5'($urandom_range(0, 7));
      eval(); tick();
      r = $urandom_range(0, 7);
      chk("rand_cnt", 32'(dut.cnt[r]), mcnt[r]);
    end
    rst = 0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
